// File: rtl/dbg_spi_pkg.sv
// rtl/dbg_spi_pkg.sv - shared types and width helpers for the debug SPI probe
package dbg_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_STEP  = 3'd4
  } state_t;

  localparam int FRAME_CNT_W = 16;

  // Bits needed to hold the value n (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_shift_lane.sv
// rtl/spi_shift_lane.sv - one SPI lane: MSB-first shift register with gated cs/mosi
module spi_shift_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         mosi,
  output logic         cs
);

  logic [W-1:0] sreg;
  logic         en_q;

  // Reset doubles as end-of-frame release: cs high, mosi low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      en_q <= 1'b0;
      mosi <= 1'b0;
      cs   <= 1'b1;
    end else if (load) begin
      sreg <= din;
      en_q <= en;
      cs   <= ~en;
      mosi <= en & din[W-1];
    end else if (shift) begin
      sreg <= sreg << 1;
      mosi <= en_q & sreg[W-2];
    end
  end

endmodule

// File: rtl/dbg_spi_probe.sv
// rtl/dbg_spi_probe.sv - snapshots CH probe words, streams them on CH SPI lanes, then steps the CPU
module dbg_spi_probe
  import dbg_spi_pkg::*;
#(
  parameter int CH  = 3,
  parameter int W   = 32,
  parameter int DIV = 100,
  parameter int GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH*W-1:0]        data,
  input  logic [CH-1:0]          mask,
  input  logic                   run,
  input  logic                   step_req,
  output logic                   cpu_step,
  output logic                   sck,
  output logic [CH-1:0]          cs,
  output logic [CH-1:0]          mosi,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int BW = cnt_w(W);
  localparam int DW = cnt_w(DIV - 1);
  localparam int GW = cnt_w(2 * GAP * DIV);

  state_t         state, state_next;
  logic [BW-1:0]  bit_cnt;
  logic [DW-1:0]  div_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           step_pending;
  logic           load;
  logic           div_tc;
  logic           fall;
  logic           frame_end;
  logic           lane_shift;
  logic           gap_done;

  assign div_tc     = (div_cnt == DW'(DIV - 1));
  assign fall       = (state == ST_SHIFT) && div_tc && sck;
  assign frame_end  = fall && (bit_cnt == '0);
  assign lane_shift = fall && (bit_cnt != '0);
  assign gap_done   = (gap_cnt == GW'(2 * GAP * DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    cpu_step   = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (run || step_req || step_pending) state_next = ST_LOAD;
      ST_LOAD: begin
        load       = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: if (frame_end) state_next = (GAP == 0) ? ST_STEP : ST_GAP;
      ST_GAP:   if (gap_done) state_next = ST_STEP;
      ST_STEP: begin
        cpu_step   = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // sck divider, bit/gap counters, pending single-step request and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck          <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      step_pending <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (state == ST_IDLE)  step_pending <= 1'b0;
      else if (step_req)     step_pending <= 1'b1;
      case (state)
        ST_LOAD: begin
          bit_cnt <= BW'(W);
          div_cnt <= '0;
          gap_cnt <= '0;
          sck     <= 1'b0;
        end
        ST_SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            sck     <= ~sck;
            if (!sck) bit_cnt <= bit_cnt - BW'(1);
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        ST_GAP:  gap_cnt   <= gap_cnt + GW'(1);
        ST_STEP: frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    spi_shift_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst   (rst | frame_end),
      .load  (load),
      .shift (lane_shift),
      .en    (mask[i]),
      .din   (data[i*W +: W]),
      .mosi  (mosi[i]),
      .cs    (cs[i])
    );
  end

endmodule

// File: tb/tb_dbg_spi_probe.sv
// tb/tb_dbg_spi_probe.sv - scoreboard bench for dbg_spi_probe (CH=3, W=8, DIV=2, GAP=2)
module tb_dbg_spi_probe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] data = '0;
  logic [2:0]  mask = '0;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic        cpu_step;
  logic        sck;
  logic [2:0]  cs;
  logic [2:0]  mosi;
  logic        busy;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Expected frame: {mask, lane2, lane1, lane0}
  logic [26:0] exp_q[$];

  dbg_spi_probe #(.CH(3), .W(8), .DIV(2), .GAP(2)) dut (
    .clk(clk), .rst(rst), .data(data), .mask(mask), .run(run), .step_req(step_req),
    .cpu_step(cpu_step), .sck(sck), .cs(cs), .mosi(mosi), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (required finish before 2 ms)");
    $fatal(1, "watchdog");
  end

  // Monitor: captures lane bytes on sck rising edges, compares a frame at cpu_step
  logic [7:0] cap [3];
  int nbits [3];
  int cslow [3];
  logic stray;
  logic sck_d;
  logic cs_all_d;
  int rise_cyc;
  int steps_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin cap[i] = '0; nbits[i] = 0; cslow[i] = 0; end
      stray = 1'b0; sck_d = 1'b0; cs_all_d = 1'b1; rise_cyc = -1;
    end else begin
      if (sck && !sck_d)
        for (int i = 0; i < 3; i++)
          if (!cs[i]) begin cap[i] = {cap[i][6:0], mosi[i]}; nbits[i]++; end
      for (int i = 0; i < 3; i++) begin
        if (!cs[i]) cslow[i]++;
        if (cs[i] && mosi[i]) stray = 1'b1;
      end
      if (&cs && !cs_all_d) rise_cyc = cyc;
      if (cpu_step) begin
        logic [26:0] e;
        steps_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_step: cpu_step at cycle %0d with no frame expected", cyc);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 3; i++) begin
            if (e[24+i]) begin
              checks++;
              if (cap[i] !== e[i*8 +: 8] || nbits[i] != 8) begin
                errors++;
                $display("FAIL sb_lane%0d_byte: got %h (%0d bits) required %h (8 bits)", i, cap[i], nbits[i], e[i*8 +: 8]);
              end
              checks++;
              if (cslow[i] != 32) begin
                errors++;
                $display("FAIL sb_lane%0d_cs_low: got %0d cycles required 32", i, cslow[i]);
              end
            end else begin
              checks++;
              if (cslow[i] != 0 || nbits[i] != 0) begin
                errors++;
                $display("FAIL sb_lane%0d_masked: cs low %0d cycles, %0d bits, required 0/0", i, cslow[i], nbits[i]);
              end
            end
          end
          checks++;
          if (stray) begin
            errors++;
            $display("FAIL sb_mosi_idle: mosi=1 while cs high, required 0");
          end
          if (|e[26:24]) begin
            checks++;
            if (cyc - rise_cyc != 8) begin
              errors++;
              $display("FAIL sb_step_delay: cpu_step %0d cycles after cs rise, required 8", cyc - rise_cyc);
            end
          end
        end
        for (int i = 0; i < 3; i++) begin cap[i] = '0; nbits[i] = 0; cslow[i] = 0; end
        stray = 1'b0; rise_cyc = -1;
      end
      sck_d = sck;
      cs_all_d = &cs;
    end
  end

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_step();
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
  endtask

  task automatic wait_step(input int budget, output int at);
    int n = 0;
    at = -1;
    while (n < budget) begin
      @(negedge clk);
      if (cpu_step) begin at = cyc; break; end
      n++;
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL wait_step: no cpu_step within %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    int t;
    int s0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sck, cs, mosi, busy, cpu_step} !== {1'b0, 3'b111, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: sck=%b cs=%b mosi=%b busy=%b step=%b required 0 111 000 0 0", sck, cs, mosi, busy, cpu_step);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    rst = 1'b0;
    data = {8'hFF, 8'h3C, 8'hA5}; mask = 3'b111;
    exp_q.push_back({3'b111, 24'hFF3CA5});
    pulse_step();
    wait_step(200, t);
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_pre_cnt: got %0d required 1", frame_cnt);
    end
    pulse_step();
    repeat (10) @(negedge clk);
    checks++;
    if (cs !== 3'b000) begin
      errors++;
      $display("FAIL reset_in_shift: cs=%b required 000 before reset", cs);
    end
    s0 = steps_seen;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sck, cs, mosi, busy, cpu_step} !== {1'b0, 3'b111, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_frame: sck=%b cs=%b mosi=%b busy=%b step=%b required 0 111 000 0 0", sck, cs, mosi, busy, cpu_step);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_cnt: got %0d required 0", frame_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (steps_seen != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_step: steps %0d busy=%b required %0d busy=0", steps_seen, busy, s0);
    end
  endtask

  task automatic test_single_step();
    int t;
    do_reset();
    data = {8'hFF, 8'h3C, 8'hA5}; mask = 3'b111;
    exp_q.push_back({3'b111, 24'hFF3CA5});
    pulse_step();
    repeat (3) @(negedge clk);
    data = 24'h123456; mask = 3'b000;
    wait_step(200, t);
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0 || cpu_step !== 1'b0) begin
      errors++;
      $display("FAIL single_after: cnt=%0d busy=%b step=%b required 1 0 0", frame_cnt, busy, cpu_step);
    end
  endtask

  task automatic test_mask();
    int t;
    do_reset();
    data = {8'hFF, 8'h3C, 8'hA5}; mask = 3'b010;
    exp_q.push_back({3'b010, 24'hFF3CA5});
    pulse_step();
    wait_step(200, t);
    mask = 3'b000;
    exp_q.push_back({3'b000, 24'hFF3CA5});
    pulse_step();
    wait_step(200, t);
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL mask_cnt: got %0d required 2", frame_cnt);
    end
  endtask

  task automatic test_free_run();
    int t1, t2, t3;
    do_reset();
    data = {8'h81, 8'h7E, 8'hC3}; mask = 3'b111;
    repeat (3) exp_q.push_back({3'b111, 24'h817EC3});
    @(negedge clk); run = 1'b1;
    wait_step(200, t1);
    wait_step(200, t2);
    wait_step(200, t3);
    run = 1'b0;
    checks++;
    if (t2 - t1 != 43 || t3 - t2 != 43) begin
      errors++;
      $display("FAIL free_run_period: spacing %0d/%0d required 43/43", t2 - t1, t3 - t2);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL free_run_end: cnt=%0d busy=%b required 3 0", frame_cnt, busy);
    end
  endtask

  task automatic test_run_drop();
    int t;
    do_reset();
    data = {8'h00, 8'hF0, 8'h0F}; mask = 3'b101;
    repeat (2) exp_q.push_back({3'b101, 24'h00F00F});
    @(negedge clk); run = 1'b1;
    wait_step(200, t);
    repeat (12) @(negedge clk);
    run = 1'b0;
    wait_step(200, t);
    repeat (60) @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_drop: cnt=%0d busy=%b required 2 0", frame_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    do_reset();
    data = {8'h5A, 8'h96, 8'h69}; mask = 3'b111;
    repeat (2) exp_q.push_back({3'b111, 24'h5A9669});
    pulse_step();
    repeat (8) @(negedge clk);
    pulse_step();
    pulse_step();
    wait_step(200, t);
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL b2b_first: cnt=%0d required 1", frame_cnt);
    end
    wait_step(200, t);
    repeat (60) @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: cnt=%0d busy=%b required 2 0", frame_cnt, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_queue: %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_mask();
    test_free_run();
    test_run_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbg_spi_probe.md
Name: dbg_spi_probe

Overview:
- Parametrised successor to the SoC debug-SPI path: snapshots CH probe words of W bits each and streams them MSB-first on CH parallel SPI lanes that share one generated sck.
- After each frame, issues a one-cycle cpu_step enable that advances the CPU by exactly one cycle.
- Adds per-channel gating (mask), free-run and single-step modes, an inter-frame gap, and a frame counter.
- Sits in the SoC top, between the CPU debug taps (pc, imem data, dmem wdata, ...) and the board pins.

Parameters:
- CH, 3: number of SPI lanes / probe words.
- W, 32: bits per probe word.
- DIV, 100: sck half-period in clk cycles; must be >= 1.
- GAP, 2: idle sck periods, with cs high, between the end of a frame and cpu_step.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data  in  CH*W  probe words; lane i = data[i*W +: W].
- mask  in  CH  per-lane enable for the next frame (e.g. tie the dmem lane to dmem_write).
- run  in  1  level; free-run, one frame per CPU step.
- step_req  in  1  one-cycle pulse; request a single frame plus step.
- cpu_step  out  1  one-clk-cycle pulse; CPU clock enable.
- sck  out  1  shared SPI clock, idle low.
- cs  out  CH  per-lane chip select, active-low.
- mosi  out  CH  per-lane serial data.
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  16  number of completed frames.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Values while rst=1 and on the first clk after it: state=IDLE, sck=0, cs=all 1, mosi=0, cpu_step=0, busy=0, frame_cnt=0, step_pending=0.
- Reset mid-frame: all outputs return to reset values on the next clk edge; no cpu_step is issued.
- FSM states: IDLE, LOAD, SHIFT, GAP, STEP.
- IDLE
  - go to LOAD when run=1, step_req=1, or step_pending=1.
  - consumes step_pending.
- LOAD (1 cycle)
  - latch data into the lane shift registers and latch mask.
  - mosi[i] = mask[i] ? data_i[W-1] : 0.
  - cs[i] = ~mask[i].
  - bit_cnt=W, div_cnt=0, sck=0.
  - go to SHIFT.
- SHIFT
  - div_cnt counts 0..DIV-1. At terminal count, sck toggles and div_cnt returns to 0.
  - Rising toggle: bit_cnt decrements.
  - Falling toggle with bit_cnt!=0: enabled lanes shift left and present the next bit on mosi. Data changes on the falling edge, so the receiver samples on the rising edge.
  - Falling toggle with bit_cnt==0: cs=all 1, mosi=0, go to GAP.
  - SHIFT lasts exactly 2*W*DIV cycles; W rising edges are produced.
- GAP
  - sck=0, cs=all 1, lasting 2*GAP*DIV cycles. GAP=0 gives 0 cycles (go straight to STEP).
  - then go to STEP.
- STEP (1 cycle)
  - cpu_step=1, frame_cnt+1 (wraps 0xFFFF to 0).
  - go to IDLE.
- Frame period in free-run: 2*DIV*(W+GAP)+3 clk cycles (LOAD + SHIFT + GAP + STEP + IDLE).
- Masked lanes: cs stays high and mosi stays 0 for the whole frame. Frame timing is unchanged.
- mask=0 (all lanes): the frame still times out normally and cpu_step is still issued.
- Inputs are sampled only in LOAD. Changes to data or mask mid-frame have no effect on the current frame.
- step_req while busy: sets step_pending (depth 1; further requests are dropped). It is serviced after the next IDLE.
- step_req together with run=1: only one frame starts.
- run deasserted mid-frame: the current frame completes, including cpu_step, then the block stays in IDLE.
- cpu_step is never asserted outside STEP.

Decomposition:
- Package dbg_spi_pkg:
  - state enum (IDLE, LOAD, SHIFT, GAP, STEP).
  - FRAME_CNT_W=16.
  - localparam helpers for the bit_cnt width ($clog2(W+1)) and the div_cnt width.
- Sub-module spi_shift_lane (ports: clk, rst, load, shift, en, din[W], mosi, cs), instantiated CH times via generate.
- sck divider and FSM stay in dbg_spi_probe.

Test Plan:
- Reset: hold rst 3 cycles during SHIFT -> next cycle sck=0, cs=3'b111, mosi=0, busy=0, frame_cnt=0; no cpu_step.
- Single step (W=8, DIV=2, GAP=2, mask=3'b111, data={8'hFF,8'h3C,8'hA5}), step_req pulse:
  - bytes sampled on sck rising edges: lane0=A5, lane1=3C, lane2=FF.
  - cs low for exactly 32 clk.
  - one cpu_step, 8 cycles after cs rises.
  - frame_cnt=1.
- Mask 3'b010, same data -> only cs[1] falls and lane1=3C. cs[0] and cs[2] stay high, mosi[0] and mosi[2] stay 0, cpu_step still pulses.
- Free-run: run=1 for 3 frames (W=8, DIV=2, GAP=2) -> cpu_step pulses spaced exactly 43 cycles; frame_cnt=3.
- run dropped mid-SHIFT of frame 2 -> frame 2 completes, frame_cnt=2, then busy=0.
- Two step_req pulses during SHIFT -> exactly one extra frame (frame_cnt 1 -> 2), then IDLE.
